// File: rtl/core_pkg.sv
// core_pkg: shared CSR op type, CSR addresses, mstatus bit positions and exception causes
package core_pkg;
  typedef enum logic [1:0] {CSR_READ, CSR_WRITE, CSR_SET, CSR_CLEAR} csr_op_t;
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;
  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam logic [4:0] EXC_CAUSE_INSTR_MISALIGNED = 5'd0;
  localparam logic [4:0] EXC_CAUSE_ILLEGAL_INSTR    = 5'd2;
  localparam logic [4:0] EXC_CAUSE_BREAKPOINT       = 5'd3;
  localparam logic [4:0] EXC_CAUSE_LOAD_MISALIGNED  = 5'd4;
  localparam logic [4:0] EXC_CAUSE_STORE_MISALIGNED = 5'd6;
  localparam logic [4:0] EXC_CAUSE_ECALL_M          = 5'd11;
endpackage

// File: rtl/csr_counter64.sv
// csr_counter64: 64-bit wrapping counter where a half-write replaces the increment for that cycle
module csr_counter64 (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        inc_i,
  input  logic        wr_lo_i,
  input  logic        wr_hi_i,
  input  logic [31:0] wdata_i,
  output logic [63:0] value_o
);
  logic [63:0] cnt_q, cnt_d;
  always_comb cnt_d = wr_lo_i ? {cnt_q[63:32], wdata_i} : wr_hi_i ? {wdata_i, cnt_q[31:0]} : cnt_q + {63'b0, inc_i};
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
  assign value_o = cnt_q;
endmodule

// File: rtl/csr_trap_unit.sv
// csr_trap_unit: machine-mode CSR file, trap entry/mret sequencing and mcycle/minstret counters
import core_pkg::*;
module csr_trap_unit #(
  parameter logic [31:0] HART_ID    = 32'd0,
  parameter logic [31:0] MISA_VALUE = 32'h40000100
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        save_pc_id_i,
  input  logic        save_pc_ex_i,
  input  logic [31:0] pc_id_i,
  input  logic [31:0] pc_ex_i,
  input  logic [4:0]  exception_cause_i,
  input  logic [31:0] tval_i,
  input  logic        mret_ex_i,
  input  logic        csr_en_ex_i,
  input  csr_op_t     csr_op_ex_i,
  input  logic [11:0] csr_addr_ex_i,
  input  logic [31:0] csr_wdata_ex_i,
  input  logic        instr_retired_i,
  output logic [31:0] csr_rdata_o,
  output logic        csr_illegal_o,
  output logic        trap_taken_o,
  output logic [31:0] trap_target_o,
  output logic [31:0] mret_target_o,
  output logic        mstatus_mie_o
);
  logic mie_q, mie_d, mpie_q, mpie_d, mie_w, mpie_w;
  logic [31:0] mtvec_q, mtvec_d, mepc_q, mepc_d, mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d, mscratch_q, mscratch_d;
  logic [31:0] mstatus, wval;
  logic [63:0] mcycle, minstret;
  logic [11:0] wa;
  logic known, wr_req, wr_en, trap;
  assign mstatus = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
  always_comb begin
    known = 1'b1;
    csr_rdata_o = '0;
    case (csr_addr_ex_i)
      CSR_MSTATUS:   csr_rdata_o = mstatus;
      CSR_MISA:      csr_rdata_o = MISA_VALUE;
      CSR_MTVEC:     csr_rdata_o = {mtvec_q[31:2], 2'b00};
      CSR_MSCRATCH:  csr_rdata_o = mscratch_q;
      CSR_MEPC:      csr_rdata_o = {mepc_q[31:2], 2'b00};
      CSR_MCAUSE:    csr_rdata_o = mcause_q;
      CSR_MTVAL:     csr_rdata_o = mtval_q;
      CSR_MCYCLE:    csr_rdata_o = mcycle[31:0];
      CSR_MCYCLEH:   csr_rdata_o = mcycle[63:32];
      CSR_MINSTRET:  csr_rdata_o = minstret[31:0];
      CSR_MINSTRETH: csr_rdata_o = minstret[63:32];
      CSR_MHARTID:   csr_rdata_o = HART_ID;
      default:       known = 1'b0;
    endcase
  end
  assign wr_req = csr_op_ex_i == CSR_WRITE || (csr_op_ex_i != CSR_READ && csr_wdata_ex_i != '0);
  assign csr_illegal_o = csr_en_ex_i & (~known | (csr_addr_ex_i[11:10] == 2'b11 & wr_req));
  assign wr_en = csr_en_ex_i & wr_req & ~csr_illegal_o & ~save_pc_ex_i;
  assign wa = wr_en ? csr_addr_ex_i : 12'h000;
  assign wval = csr_op_ex_i == CSR_WRITE ? csr_wdata_ex_i :
                csr_op_ex_i == CSR_SET ? csr_rdata_o | csr_wdata_ex_i : csr_rdata_o & ~csr_wdata_ex_i;
  assign trap = save_pc_id_i | save_pc_ex_i;
  assign mie_w = wa == CSR_MSTATUS ? wval[MSTATUS_MIE_BIT] : mie_q;
  assign mpie_w = wa == CSR_MSTATUS ? wval[MSTATUS_MPIE_BIT] : mpie_q;
  always_comb begin
    mie_d = trap ? 1'b0 : mret_ex_i ? mpie_w : mie_w;
    mpie_d = trap ? mie_w : mret_ex_i ? 1'b1 : mpie_w;
    mepc_d = trap ? (save_pc_ex_i ? pc_ex_i : pc_id_i) : wa == CSR_MEPC ? wval : mepc_q;
    mcause_d = trap ? {27'b0, exception_cause_i} : wa == CSR_MCAUSE ? wval : mcause_q;
    mtval_d = trap ? tval_i : wa == CSR_MTVAL ? wval : mtval_q;
    mtvec_d = wa == CSR_MTVEC ? wval : mtvec_q;
    mscratch_d = wa == CSR_MSCRATCH ? wval : mscratch_q;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mie_q <= 1'b0;
      mpie_q <= 1'b0;
      mtvec_q <= '0;
      mepc_q <= '0;
      mcause_q <= '0;
      mtval_q <= '0;
      mscratch_q <= '0;
    end else begin
      mie_q <= mie_d;
      mpie_q <= mpie_d;
      mtvec_q <= mtvec_d;
      mepc_q <= mepc_d;
      mcause_q <= mcause_d;
      mtval_q <= mtval_d;
      mscratch_q <= mscratch_d;
    end
  end
  csr_counter64 u_mcycle (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (1'b1),
    .wr_lo_i (wa == CSR_MCYCLE),
    .wr_hi_i (wa == CSR_MCYCLEH),
    .wdata_i (wval),
    .value_o (mcycle)
  );
  csr_counter64 u_minstret (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .inc_i   (instr_retired_i),
    .wr_lo_i (wa == CSR_MINSTRET),
    .wr_hi_i (wa == CSR_MINSTRETH),
    .wdata_i (wval),
    .value_o (minstret)
  );
  assign trap_taken_o = trap;
  assign trap_target_o = {mtvec_q[31:2], 2'b00};
  assign mret_target_o = {mepc_q[31:2], 2'b00};
  assign mstatus_mie_o = mie_q;
endmodule

// File: tb/tb_csr_trap_unit.sv
// tb_csr_trap_unit: directed and randomized checks of csr_trap_unit against a behavioural CSR model
module tb_csr_trap_unit;
  import core_pkg::*;
  localparam logic [31:0] HART = 32'h5;
  localparam logic [31:0] MISA = 32'h40000100;
  logic clk = 1'b0, rst = 1'b1;
  logic sid, sex, mret, en, ret;
  logic [31:0] pcid, pcex, tval, wd;
  logic [4:0] cause;
  csr_op_t op;
  logic [11:0] addr;
  logic [31:0] rdata, tt, mt;
  logic ill, taken, mie_o;
  csr_trap_unit #(.HART_ID(HART), .MISA_VALUE(MISA)) dut (
    .clk_i(clk), .rst_i(rst), .save_pc_id_i(sid), .save_pc_ex_i(sex), .pc_id_i(pcid), .pc_ex_i(pcex),
    .exception_cause_i(cause), .tval_i(tval), .mret_ex_i(mret), .csr_en_ex_i(en), .csr_op_ex_i(op),
    .csr_addr_ex_i(addr), .csr_wdata_ex_i(wd), .instr_retired_i(ret), .csr_rdata_o(rdata),
    .csr_illegal_o(ill), .trap_taken_o(taken), .trap_target_o(tt), .mret_target_o(mt), .mstatus_mie_o(mie_o)
  );
  always #5 clk = ~clk;
  int n_tests = 0, n_fail = 0;
  logic m_mie, m_mpie;
  logic [31:0] m_mtvec, m_mepc, m_mcause, m_mtval, m_mscratch;
  logic [63:0] m_cyc, m_ret;
  logic [31:0] s_rdata, s_tt, s_mt;
  logic s_ill;
  logic [11:0] addrs [15] = '{12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                              12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hF14, 12'h7C0, 12'h344, 12'hC00};
  task automatic chk(string tag, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask
  function automatic logic [31:0] m_read(logic [11:0] a, output logic known);
    known = 1'b1;
    case (a)
      12'h300: return 32'h1800 | (32'(m_mpie) << 7) | (32'(m_mie) << 3);
      12'h301: return MISA;
      12'h305: return m_mtvec & ~32'h3;
      12'h340: return m_mscratch;
      12'h341: return m_mepc & ~32'h3;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'hB00: return m_cyc[31:0];
      12'hB80: return m_cyc[63:32];
      12'hB02: return m_ret[31:0];
      12'hB82: return m_ret[63:32];
      12'hF14: return HART;
      default: begin known = 1'b0; return 32'h0; end
    endcase
  endfunction
  task automatic idle();
    sid = 0; sex = 0; mret = 0; en = 0; ret = 0; op = CSR_READ; addr = 12'h0;
    wd = 0; pcid = 0; pcex = 0; tval = 0; cause = 0;
  endtask
  task automatic csr(csr_op_t o, logic [11:0] a, logic [31:0] d);
    idle(); en = 1; op = o; addr = a; wd = d;
  endtask
  task automatic cycle();
    logic known, e_ill, wr;
    logic [31:0] old, nv;
    logic [63:0] c, r;
    old = m_read(addr, known);
    e_ill = en && (!known || (addr[11:10] == 2'b11 && (op == CSR_WRITE || (op != CSR_READ && wd != 0))));
    #4;
    s_rdata = rdata; s_ill = ill; s_tt = tt; s_mt = mt;
    if (en) chk("rdata", rdata, old);
    chk("illegal", ill, e_ill);
    chk("trap_taken", taken, sid | sex);
    chk("trap_target", tt, m_mtvec & ~32'h3);
    chk("mret_target", mt, m_mepc & ~32'h3);
    chk("mie", mie_o, m_mie);
    @(posedge clk);
    wr = en && !e_ill && !sex && op != CSR_READ && (op == CSR_WRITE || wd != 0);
    nv = op == CSR_WRITE ? wd : op == CSR_SET ? (old | wd) : (old & ~wd);
    c = m_cyc + 1;
    r = m_ret + 64'(ret);
    if (wr)
      case (addr)
        12'h300: begin m_mie = nv[3]; m_mpie = nv[7]; end
        12'h305: m_mtvec = nv;
        12'h340: m_mscratch = nv;
        12'h341: m_mepc = nv;
        12'h342: m_mcause = nv;
        12'h343: m_mtval = nv;
        12'hB00: c = {m_cyc[63:32], nv};
        12'hB80: c = {nv, m_cyc[31:0]};
        12'hB02: r = {m_ret[63:32], nv};
        12'hB82: r = {nv, m_ret[31:0]};
        default: ;
      endcase
    m_cyc = c;
    m_ret = r;
    if (sid || sex) begin
      m_mepc = sex ? pcex : pcid;
      m_mcause = {27'b0, cause};
      m_mtval = tval;
      m_mpie = m_mie;
      m_mie = 0;
    end else if (mret) begin
      m_mie = m_mpie;
      m_mpie = 1;
    end
    #1;
  endtask
  task automatic rd(logic [11:0] a);
    csr(CSR_READ, a, $urandom);
    cycle();
  endtask
  task automatic do_reset();
    rst = 1;
    m_mie = 0; m_mpie = 0; m_mtvec = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0; m_mscratch = 0;
    m_cyc = 0; m_ret = 0;
    #1;
    chk("rst_mie", mie_o, 0);
    chk("rst_mret_target", mt, 0);
    chk("rst_trap_target", tt, 0);
    @(posedge clk);
    #1 rst = 0;
    idle();
  endtask
  initial begin
    idle();
    do_reset();
    rd(CSR_MSTATUS); chk("mstatus_reset", s_rdata, 32'h1800); chk("mstatus_ill", s_ill, 0);
    rd(CSR_MISA); chk("misa", s_rdata, MISA);
    rd(CSR_MHARTID); chk("mhartid", s_rdata, HART);
    csr(CSR_WRITE, CSR_MTVEC, 32'h8000_0103); cycle();
    rd(CSR_MTVEC); chk("mtvec_rd", s_rdata, 32'h8000_0100);
    idle(); sex = 1; pcex = 32'h100; cause = EXC_CAUSE_INSTR_MISALIGNED; cycle();
    chk("trap_target_now", s_tt, 32'h8000_0100);
    rd(CSR_MEPC); chk("mepc_after_trap", s_rdata, 32'h100);
    rd(CSR_MCAUSE); chk("mcause_after_trap", s_rdata, 0);
    csr(CSR_WRITE, CSR_MSTATUS, 32'h8); cycle();
    idle(); sid = 1; pcid = 32'h180; cause = EXC_CAUSE_ILLEGAL_INSTR; tval = 32'hDEAD; cycle();
    rd(CSR_MSTATUS); chk("mstatus_trap", s_rdata, 32'h1880);
    rd(CSR_MTVAL); chk("mtval_trap", s_rdata, 32'hDEAD);
    idle(); mret = 1; cycle(); chk("mret_target_now", s_mt, 32'h180);
    rd(CSR_MSTATUS); chk("mstatus_mret", s_rdata, 32'h1888);
    csr(CSR_WRITE, CSR_MEPC, 32'h500); sid = 1; pcid = 32'h204; cycle();
    rd(CSR_MEPC); chk("mepc_trap_over_write", s_rdata, 32'h204);
    csr(CSR_WRITE, CSR_MSCRATCH, 7); cycle();
    csr(CSR_WRITE, CSR_MSCRATCH, 5); sex = 1; pcex = 32'h300; cycle();
    rd(CSR_MSCRATCH); chk("mscratch_suppressed", s_rdata, 7);
    csr(CSR_WRITE, CSR_MCYCLE, 32'hFFFF_FFFF); cycle();
    csr(CSR_WRITE, CSR_MCYCLEH, 0); cycle();
    idle(); cycle();
    rd(CSR_MCYCLE); chk("mcycle_lo_wrap", s_rdata, 0);
    rd(CSR_MCYCLEH); chk("mcycle_hi_carry", s_rdata, 1);
    csr(CSR_WRITE, CSR_MINSTRET, 0); cycle();
    for (int i = 0; i < 3; i++) begin idle(); ret = 1; cycle(); end
    rd(CSR_MINSTRET); chk("minstret_3", s_rdata, 3);
    csr(CSR_WRITE, CSR_MHARTID, 32'h55); cycle(); chk("ro_write_ill", s_ill, 1);
    rd(CSR_MHARTID); chk("mhartid_kept", s_rdata, HART);
    csr(CSR_SET, CSR_MHARTID, 0); cycle(); chk("ro_set0_ill", s_ill, 0);
    rd(12'h7C0); chk("unknown_ill", s_ill, 1);
    csr(CSR_WRITE, CSR_MSCRATCH, 9); sid = 1; pcid = 32'h44;
    do_reset();
    rd(CSR_MSCRATCH); chk("mscratch_after_rst", s_rdata, 0);
    rd(CSR_MEPC); chk("mepc_after_rst", s_rdata, 0);
    for (int i = 0; i < 800; i++) begin
      idle();
      if ($urandom_range(0, 2) != 0) begin
        en = 1;
        op = csr_op_t'($urandom_range(0, 3));
        addr = $urandom_range(0, 15) == 0 ? 12'($urandom) : addrs[$urandom_range(0, 14)];
        wd = $urandom_range(0, 3) == 0 ? 32'h0 : $urandom;
      end else mret = $urandom_range(0, 3) == 0;
      sid = $urandom_range(0, 9) == 0;
      sex = $urandom_range(0, 9) == 0;
      pcid = $urandom; pcex = $urandom; tval = $urandom; cause = 5'($urandom);
      ret = 1'($urandom_range(0, 1));
      if (sid && !sex && en && addr == CSR_MSTATUS) sid = 0;
      cycle();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
